// File: rtl/mont_mult_seq_ctrl_pkg.sv
// mont_ctrl_pkg: shared state encoding, default width and counter sizing for the Montgomery sequencer
package mont_ctrl_pkg;
    localparam int K_BITS_DEF = 8;
    typedef enum logic [1:0] {ST_IDLE, ST_ITER, ST_SUB, ST_DONE} state_t;
    function automatic int clog2(input int n);
        int w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction
endpackage

// File: rtl/mont_mult_seq_ctrl_if.sv
// mont_mult_seq_ctrl_if: operand-issue and result handshakes of the Montgomery sequencer
interface mont_mult_seq_ctrl_if import mont_ctrl_pkg::*; #(parameter int K_BITS = K_BITS_DEF);
    logic              i_valid, o_ready, o_valid, i_ready, o_err;
    logic [K_BITS-1:0] i_A, i_B, i_M, o_P;
    modport master(output i_valid, i_A, i_B, i_M, i_ready, input o_ready, o_valid, o_P, o_err);
    modport slave(input i_valid, i_A, i_B, i_M, i_ready, output o_ready, o_valid, o_P, o_err);
endinterface

// File: rtl/mont_mult_seq_ctrl_sub.sv
// Subtractor_k_plus_1_logical: k+1-bit two's-complement difference used for the final correction
module Subtractor_k_plus_1_logical #(parameter int K_BITS = 8) (
    input  logic [K_BITS:0] a,
    input  logic [K_BITS:0] b,
    output logic [K_BITS:0] d
);
    assign d = a - b;
endmodule

// File: rtl/mont_mult_seq_ctrl.sv
// mont_mult_seq_ctrl: bit-serial radix-2 Montgomery multiply P = A*B*2^-K mod M
// MONT_OPERAND_CHK_EN adds operand range/parity checking at accept with o_err reporting.
module mont_mult_seq_ctrl import mont_ctrl_pkg::*; #(parameter int K_BITS = K_BITS_DEF) (
    input logic i_clk,
    input logic i_rst_n,
    mont_mult_seq_ctrl_if.slave bus
);
    localparam int CW = clog2(K_BITS);
    localparam int W = K_BITS + 2;
    state_t            state;
    logic [K_BITS-1:0] a_r, b_r, m_r;
    logic [W-1:0]      s, t1, t2;
    logic [CW-1:0]     cnt;
    logic [K_BITS:0]   d;
    logic              chk_fail;
    // S < 2M and B < M keep T2 < 4M, so k+2 bits never overflow
    assign t1 = s + (a_r[cnt] ? {2'b00, b_r} : W'(0));
    assign t2 = t1 + (t1[0] ? {2'b00, m_r} : W'(0));
    Subtractor_k_plus_1_logical #(.K_BITS(K_BITS)) u_sub (
        .a(s[K_BITS:0]),
        .b({1'b0, m_r}),
        .d(d)
    );
`ifdef MONT_OPERAND_CHK_EN
    assign chk_fail = !(bus.i_M[0] && bus.i_M > K_BITS'(1) && bus.i_A < bus.i_M && bus.i_B < bus.i_M);
`else
    assign chk_fail = 1'b0;
`endif
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state       <= ST_IDLE;
            bus.o_ready <= 1'b1;
            bus.o_valid <= 1'b0;
            bus.o_P     <= '0;
            bus.o_err   <= 1'b0;
            s           <= '0;
            cnt         <= '0;
        end else begin
            case (state)
                ST_IDLE: if (bus.i_valid && bus.o_ready) begin
                    a_r         <= bus.i_A;
                    b_r         <= bus.i_B;
                    m_r         <= bus.i_M;
                    s           <= '0;
                    cnt         <= '0;
                    bus.o_ready <= 1'b0;
                    bus.o_err   <= chk_fail;
                    bus.o_P     <= '0;
                    bus.o_valid <= chk_fail;
                    state       <= chk_fail ? ST_DONE : ST_ITER;
                end
                ST_ITER: begin
                    s     <= t2 >> 1;
                    cnt   <= cnt + 1'b1;
                    state <= (cnt == CW'(K_BITS - 1)) ? ST_SUB : ST_ITER;
                end
                ST_SUB: begin
                    // sign of S-M is exact because S lies in [0, 2M)
                    bus.o_P     <= d[K_BITS] ? s[K_BITS-1:0] : d[K_BITS-1:0];
                    bus.o_valid <= 1'b1;
                    state       <= ST_DONE;
                end
                ST_DONE: if (bus.i_ready) begin
                    bus.o_valid <= 1'b0;
                    bus.o_ready <= 1'b1;
                    state       <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mont_mult_seq_ctrl.sv
// tb_mont_mult_seq_ctrl: directed Montgomery vectors (M=239, R=256, R^-1 mod M = 225)
module tb_mont_mult_seq_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n;
    logic seen;

    always #5 clk = ~clk;

    mont_mult_seq_ctrl_if #(.K_BITS(8)) bus();
    mont_mult_seq_ctrl #(.K_BITS(8)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m);
        int k = 0;
        bus.i_valid = 1'b1;
        bus.i_A = a;
        bus.i_B = b;
        bus.i_M = m;
        while (bus.o_ready !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        check("accept_rdy", 32'(bus.o_ready), 1);
        tick();
        bus.i_valid = 1'b0;
    endtask

    // counts the accept cycle as 1, up to the cycle whose edge raises o_valid
    task automatic wait_valid(output int cyc);
        cyc = 1;
        while (bus.o_valid !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
    endtask

    task automatic job(input string tag, input logic [7:0] a, input logic [7:0] b, input logic [7:0] m,
                       input logic [7:0] p, input logic e, input int lat);
        int cyc;
        start(a, b, m);
        wait_valid(cyc);
        check({tag, " lat"}, 32'(cyc), 32'(lat));
        check({tag, " P"}, 32'(bus.o_P), 32'(p));
        check({tag, " err"}, 32'(bus.o_err), 32'(e));
        bus.i_ready = 1'b1;
        tick();
        bus.i_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.i_valid = 1'b1;
        bus.i_ready = 1'b0;
        bus.i_A = 8'd5;
        bus.i_B = 8'd7;
        bus.i_M = 8'd239;
        tick();
        tick();
        check("rst ready", 32'(bus.o_ready), 1);
        check("rst valid", 32'(bus.o_valid), 0);
        check("rst P", 32'(bus.o_P), 0);
        check("rst err", 32'(bus.o_err), 0);
        rst_n = 1'b1;
        bus.i_valid = 1'b0;
        tick();

        job("5x7", 8'd5, 8'd7, 8'd239, 8'd227, 1'b0, 10);
        job("1x17", 8'd1, 8'd17, 8'd239, 8'd1, 1'b0, 10);
        job("0x200", 8'd0, 8'd200, 8'd239, 8'd0, 1'b0, 10);
        job("238x238", 8'd238, 8'd238, 8'd239, 8'd225, 1'b0, 10);
        job("100x50", 8'd100, 8'd50, 8'd239, 8'd27, 1'b0, 10);
        job("238x1", 8'd238, 8'd1, 8'd239, 8'd14, 1'b0, 10);

        start(8'd5, 8'd7, 8'd239);
        wait_valid(n);
        check("bp lat", 32'(n), 10);
        bus.i_valid = 1'b1;
        bus.i_A = 8'd1;
        bus.i_B = 8'd17;
        bus.i_M = 8'd239;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp hold valid", 32'(bus.o_valid), 1);
            check("bp hold P", 32'(bus.o_P), 227);
            check("bp hold rdy", 32'(bus.o_ready), 0);
        end
        bus.i_ready = 1'b1;
        tick();
        bus.i_ready = 1'b0;
        check("bp exit rdy", 32'(bus.o_ready), 1);
        check("bp exit valid", 32'(bus.o_valid), 0);
        tick();
        check("bp next accepted", 32'(bus.o_ready), 0);
        bus.i_valid = 1'b0;
        wait_valid(n);
        check("bp next lat", 32'(n), 10);
        check("bp next P", 32'(bus.o_P), 1);
        bus.i_ready = 1'b1;
        tick();
        bus.i_ready = 1'b0;

`ifdef MONT_OPERAND_CHK_EN
        job("chk even M", 8'd5, 8'd7, 8'd238, 8'd0, 1'b1, 1);
        job("chk A>=M", 8'd240, 8'd7, 8'd239, 8'd0, 1'b1, 1);
`endif

        start(8'd5, 8'd7, 8'd239);
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        check("abort ready", 32'(bus.o_ready), 1);
        check("abort valid", 32'(bus.o_valid), 0);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            tick();
            if (bus.o_valid !== 1'b0) seen = 1'b1;
        end
        check("abort no result", 32'(seen), 0);
        job("after abort", 8'd5, 8'd7, 8'd239, 8'd227, 1'b0, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
